// File: rtl/md_hilo_ctrl.sv
// Multiply/divide sequencer and sole HI/LO write arbiter (iterative shift-add MUL, restoring DIV).
// Define MD_FAST_MUL_EN to replace the iterative multiply with a single-cycle product in FIX.
module md_hilo_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic            hi_wr,
   output logic            lo_wr,
   output logic [XLEN-1:0] hi_wd,
   output logic [XLEN-1:0] lo_wd
);

   localparam int CW = $clog2(XLEN);
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ONES_X   = {XLEN{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_WB   = 3'd4,
      ST_MV   = 3'd5
   } state_t;

   state_t              state_r, seq_nxt_s, state_nxt_s;
   logic [CW-1:0]       cnt_r;
   logic [XLEN-1:0]     a_r, b_r;
   logic [2*XLEN-1:0]   acc_r;
   logic                is_div_r, dz_r, neg_res_r, neg_rem_r;
   logic                busy_r, done_r, hi_wr_r, lo_wr_r;
   logic [XLEN-1:0]     hi_wd_r, lo_wd_r;

   logic                signed_op_s, sgn_a_s, sgn_b_s;
   logic [XLEN-1:0]     abs_a_s, abs_b_s;
   logic [XLEN:0]       mul_sum_s, div_shift_s, div_diff_s;
   logic [2*XLEN-1:0]   mul_nxt_s, div_nxt_s, prod_s;
   logic [XLEN-1:0]     fix_hi_s, fix_lo_s;

   assign signed_op_s = (op == OP_MULT) || (op == OP_DIV);
   assign sgn_a_s     = signed_op_s & rs_val[XLEN-1];
   assign sgn_b_s     = signed_op_s & rt_val[XLEN-1];
   assign abs_a_s     = sgn_a_s ? (ZERO_X - rs_val) : rs_val;
   assign abs_b_s     = sgn_b_s ? (ZERO_X - rt_val) : rt_val;

   // Next-state selection; flush overrides every state.
   always_comb begin
      seq_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               case (op)
`ifdef MD_FAST_MUL_EN
                  OP_MULT, OP_MULTU: seq_nxt_s = ST_FIX;
`else
                  OP_MULT, OP_MULTU: seq_nxt_s = ST_MUL;
`endif
                  OP_DIV, OP_DIVU:   seq_nxt_s = (rt_val == ZERO_X) ? ST_FIX : ST_DIV;
                  OP_MTHI, OP_MTLO:  seq_nxt_s = ST_MV;
                  default:           seq_nxt_s = ST_IDLE;
               endcase
            end else begin
               seq_nxt_s = ST_IDLE;
            end
         end
         ST_MUL:  seq_nxt_s = (cnt_r == CNT_ZERO) ? ST_FIX : ST_MUL;
         ST_DIV:  seq_nxt_s = (cnt_r == CNT_ZERO) ? ST_FIX : ST_DIV;
         ST_FIX:  seq_nxt_s = ST_WB;
         ST_WB:   seq_nxt_s = ST_IDLE;
         ST_MV:   seq_nxt_s = ST_IDLE;
         default: seq_nxt_s = ST_IDLE;
      endcase
      state_nxt_s = flush ? ST_IDLE : seq_nxt_s;
   end

   // One iteration step for each engine plus the sign correction applied in FIX.
   always_comb begin
      mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, a_r};
      mul_nxt_s   = acc_r[0] ? {mul_sum_s, acc_r[XLEN-1:1]} : {1'b0, acc_r[2*XLEN-1:1]};
      div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
      div_diff_s  = div_shift_s - {1'b0, b_r};
      div_nxt_s   = div_diff_s[XLEN] ? {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0}
                                     : {div_diff_s[XLEN-1:0],  acc_r[XLEN-2:0], 1'b1};
`ifdef MD_FAST_MUL_EN
      prod_s = {ZERO_X, a_r} * {ZERO_X, b_r};
`else
      prod_s = acc_r;
`endif
      fix_hi_s = acc_r[2*XLEN-1:XLEN];
      fix_lo_s = acc_r[XLEN-1:0];
      if (dz_r) begin
         fix_hi_s = acc_r[2*XLEN-1:XLEN];
         fix_lo_s = acc_r[XLEN-1:0];
      end else if (is_div_r) begin
         fix_hi_s = neg_rem_r ? (ZERO_X - acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
         fix_lo_s = neg_res_r ? (ZERO_X - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
      end else begin
         if (neg_res_r) begin
            fix_hi_s = ~prod_s[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, (prod_s[XLEN-1:0] == ZERO_X)};
            fix_lo_s = ZERO_X - prod_s[XLEN-1:0];
         end else begin
            fix_hi_s = prod_s[2*XLEN-1:XLEN];
            fix_lo_s = prod_s[XLEN-1:0];
         end
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= CNT_ZERO;
         a_r       <= ZERO_X;
         b_r       <= ZERO_X;
         acc_r     <= {(2*XLEN){1'b0}};
         is_div_r  <= 1'b0;
         dz_r      <= 1'b0;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         hi_wr_r   <= 1'b0;
         lo_wr_r   <= 1'b0;
         hi_wd_r   <= ZERO_X;
         lo_wd_r   <= ZERO_X;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         done_r  <= (state_nxt_s == ST_WB);
         hi_wr_r <= (state_nxt_s == ST_WB) || ((state_nxt_s == ST_MV) && (op == OP_MTHI));
         lo_wr_r <= (state_nxt_s == ST_WB) || ((state_nxt_s == ST_MV) && (op == OP_MTLO));

         if (flush) begin
            cnt_r <= CNT_ZERO;
         end else if ((state_r == ST_IDLE) && start) begin
            cnt_r <= CNT_LAST;
         end else if (((state_r == ST_MUL) || (state_r == ST_DIV)) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
         end

         case (state_r)
            ST_IDLE: begin
               if (start && !flush) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        a_r       <= abs_a_s;
                        b_r       <= abs_b_s;
                        acc_r     <= {ZERO_X, abs_b_s};
                        is_div_r  <= 1'b0;
                        dz_r      <= 1'b0;
                        neg_res_r <= sgn_a_s ^ sgn_b_s;
                        neg_rem_r <= 1'b0;
                     end
                     OP_DIV, OP_DIVU: begin
                        a_r       <= abs_a_s;
                        b_r       <= abs_b_s;
                        acc_r     <= (rt_val == ZERO_X) ? {rs_val, ONES_X} : {ZERO_X, abs_a_s};
                        is_div_r  <= 1'b1;
                        dz_r      <= (rt_val == ZERO_X);
                        neg_res_r <= sgn_a_s ^ sgn_b_s;
                        neg_rem_r <= sgn_a_s;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL:  acc_r <= mul_nxt_s;
            ST_DIV:  acc_r <= div_nxt_s;
            default: ;
         endcase

         // Write data only changes when a write is about to be presented.
         if (state_nxt_s == ST_WB) begin
            hi_wd_r <= fix_hi_s;
            lo_wd_r <= fix_lo_s;
         end else if ((state_nxt_s == ST_MV) && (op == OP_MTHI)) begin
            hi_wd_r <= rs_val;
         end else if ((state_nxt_s == ST_MV) && (op == OP_MTLO)) begin
            lo_wd_r <= rs_val;
         end
      end
   end

   // A flush in WB/MV must still cancel the write presented that cycle.
   assign busy  = busy_r;
   assign done  = done_r  & ~flush;
   assign hi_wr = hi_wr_r & ~flush;
   assign lo_wr = lo_wr_r & ~flush;
   assign hi_wd = hi_wd_r;
   assign lo_wd = lo_wd_r;

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Randomised self-checking bench for md_hilo_ctrl against an arithmetic reference model.
module tb_md_hilo_ctrl;
   localparam int NC = 45;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        busy, done, hi_wr, lo_wr;
   logic [31:0] hi_wd, lo_wd;

   int n_tests = 0;
   int n_fail  = 0;

   logic        ob_busy [NC+1];
   logic        ob_hwr  [NC+1];
   logic        ob_lwr  [NC+1];
   logic        ob_done [NC+1];
   logic [31:0] ob_hwd  [NC+1];
   logic [31:0] ob_lwd  [NC+1];

   int          wb_c, idle_c, n_hwr, n_lwr, n_done;
   logic [31:0] hi_got, lo_got;

   md_hilo_ctrl #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .flush(flush), .busy(busy), .done(done), .hi_wr(hi_wr), .lo_wr(lo_wr),
      .hi_wd(hi_wd), .lo_wd(lo_wd)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint          sp;
      longint unsigned up;
      int              sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      hi = 32'h0;
      lo = 32'h0;
      case (o)
         3'd0: begin sp = longint'(sa) * longint'(sb); hi = sp[63:32]; lo = sp[31:0]; end
         3'd1: begin up = {32'h0, a} * {32'h0, b};     hi = up[63:32]; lo = up[31:0]; end
         3'd2, 3'd3: begin
            if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; end
            else if (o == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 32'h0; lo = 32'h8000_0000; end
            else if (o == 3'd2) begin hi = sa % sb; lo = sa / sb; end
            else begin hi = a % b; lo = a / b; end
         end
         default: ;
      endcase
   endfunction

   function automatic int exp_wb(input logic [2:0] o, input logic [31:0] b);
      if (o >= 3'd4) return 1;
      if (o >= 3'd2) return (b == 32'h0) ? 2 : 34;
`ifdef MD_FAST_MUL_EN
      return 2;
`else
      return 34;
`endif
   endfunction

   // Issue one op at edge 0, optionally inject an event in cycle inj_c, record cycles 1..NC.
   // inj_k: 1 = start MULT, 2 = flush+start, 3 = flush, 4 = rst.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj_c, input int inj_k);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      start = 1'b0; rs_val = $urandom; rt_val = $urandom;
      for (int c = 1; c <= NC; c++) begin
         if (c == inj_c) begin
            case (inj_k)
               1: begin start = 1'b1; op = 3'd0; rs_val = 32'd7; rt_val = 32'd9; end
               2: begin flush = 1'b1; start = 1'b1; op = 3'd0; end
               3: flush = 1'b1;
               4: rst = 1'b1;
               default: ;
            endcase
         end
         #1;
         ob_busy[c] = busy; ob_hwr[c] = hi_wr; ob_lwr[c] = lo_wr; ob_done[c] = done;
         ob_hwd[c]  = hi_wd; ob_lwd[c] = lo_wd;
         @(posedge clk); #1;
         start = 1'b0; flush = 1'b0; rst = 1'b0;
      end
      wb_c = 0; idle_c = 0; n_hwr = 0; n_lwr = 0; n_done = 0; hi_got = 32'h0; lo_got = 32'h0;
      for (int c = NC; c >= 1; c--) begin
         if (ob_hwr[c] || ob_lwr[c]) wb_c = c;
         if (!ob_busy[c]) idle_c = c;
      end
      for (int c = 1; c <= NC; c++) begin
         if (ob_hwr[c]) begin n_hwr++; hi_got = ob_hwd[c]; end
         if (ob_lwr[c]) begin n_lwr++; lo_got = ob_lwd[c]; end
         if (ob_done[c]) n_done++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; rs_val = 32'h0; rt_val = 32'h0;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      n_tests++; if ({busy, done, hi_wr, lo_wr} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl got=%b exp=0000", {busy, done, hi_wr, lo_wr}); end
      n_tests++; if ({hi_wd, lo_wd} !== 64'h0) begin n_fail++; $display("FAIL reset_wd got=%h exp=0", {hi_wd, lo_wd}); end
   endtask

   // Runs one op and checks result, write timing, pulse counts and return to IDLE.
   task automatic test_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh, el;
      int          ew;
      model(o, a, b, eh, el);
      ew = exp_wb(o, b);
      run_op(o, a, b, 0, 0);
      n_tests++; if (wb_c !== ew) begin n_fail++; $display("FAIL %s wb_cycle got=%0d exp=%0d", nm, wb_c, ew); end
      n_tests++; if (idle_c !== ew + 1) begin n_fail++; $display("FAIL %s idle_cycle got=%0d exp=%0d", nm, idle_c, ew + 1); end
      if (o <= 3'd3) begin
         n_tests++; if (hi_got !== eh || lo_got !== el) begin n_fail++; $display("FAIL %s a=%h b=%h got=%h_%h exp=%h_%h", nm, a, b, hi_got, lo_got, eh, el); end
         n_tests++; if ({n_hwr, n_lwr, n_done} !== {32'd1, 32'd1, 32'd1}) begin n_fail++; $display("FAIL %s pulses hwr=%0d lwr=%0d done=%0d exp=1,1,1", nm, n_hwr, n_lwr, n_done); end
         n_tests++; if (!ob_done[ew]) begin n_fail++; $display("FAIL %s done_at_wb got=0 exp=1", nm); end
      end
   endtask

   task automatic test_directed();
      test_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      test_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7);
      test_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2);
      test_op("divu_zero", 3'd3, 32'd100, 32'd0);
      test_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      test_op("mult_min",  3'd0, 32'h8000_0000, 32'h8000_0000);
   endtask

   task automatic test_move();
      run_op(3'd4, 32'h1234_5678, 32'h0, 0, 0);
      n_tests++; if ({ob_hwr[1], ob_lwr[1], ob_done[1], ob_busy[1]} !== 4'b1001) begin n_fail++; $display("FAIL mthi_ctl got=%b exp=1001", {ob_hwr[1], ob_lwr[1], ob_done[1], ob_busy[1]}); end
      n_tests++; if (ob_hwd[1] !== 32'h1234_5678 || n_hwr != 1 || n_lwr != 0 || idle_c != 2) begin n_fail++; $display("FAIL mthi_data got=%h n=%0d/%0d idle=%0d exp=12345678 1/0 2", ob_hwd[1], n_hwr, n_lwr, idle_c); end
      run_op(3'd5, 32'hCAFE_F00D, 32'h0, 0, 0);
      n_tests++; if ({ob_hwr[1], ob_lwr[1], ob_done[1]} !== 3'b010 || ob_lwd[1] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mtlo got=%b %h exp=010 cafef00d", {ob_hwr[1], ob_lwr[1], ob_done[1]}, ob_lwd[1]); end
      n_tests++; if (hi_wd !== 32'h1234_5678) begin n_fail++; $display("FAIL hi_hold got=%h exp=12345678", hi_wd); end
      run_op(3'd4, 32'h5555_AAAA, 32'h0, 1, 3);
      n_tests++; if (n_hwr != 0 || n_lwr != 0 || ob_busy[2]) begin n_fail++; $display("FAIL mv_flush writes=%0d/%0d busy2=%b exp=0/0 0", n_hwr, n_lwr, ob_busy[2]); end
      run_op(3'd6, 32'h1, 32'h1, 0, 0);
      n_tests++; if (idle_c != 1 || n_hwr != 0 || n_lwr != 0) begin n_fail++; $display("FAIL op6_ignored idle=%0d writes=%0d/%0d exp=1 0/0", idle_c, n_hwr, n_lwr); end
   endtask

   task automatic test_flush();
      int nb;
      run_op(3'd3, 32'd1000, 32'd3, 10, 2);
      nb = 0;
      for (int c = 11; c <= 40; c++) if (ob_busy[c]) nb++;
      n_tests++; if (!ob_busy[10] || idle_c != 11 || nb != 0) begin n_fail++; $display("FAIL flush_mid busy10=%b idle=%0d busy_after=%0d exp=1 11 0", ob_busy[10], idle_c, nb); end
      n_tests++; if (n_hwr != 0 || n_lwr != 0 || n_done != 0) begin n_fail++; $display("FAIL flush_mid_writes got=%0d/%0d/%0d exp=0/0/0", n_hwr, n_lwr, n_done); end
      run_op(3'd3, 32'd1000, 32'd3, 34, 3);
      n_tests++; if (n_hwr != 0 || n_lwr != 0 || n_done != 0 || !ob_busy[34] || idle_c != 35) begin n_fail++; $display("FAIL flush_wb writes=%0d/%0d done=%0d busy34=%b idle=%0d exp=0/0 0 1 35", n_hwr, n_lwr, n_done, ob_busy[34], idle_c); end
   endtask

   task automatic test_back_to_back();
      run_op(3'd3, 32'd9, 32'd2, 5, 1);
      n_tests++; if (wb_c != 34 || hi_got !== 32'd1 || lo_got !== 32'd4) begin n_fail++; $display("FAIL busy_ignore wb=%0d got=%h_%h exp=34 1_4", wb_c, hi_got, lo_got); end
      n_tests++; if (n_hwr != 1 || idle_c != 35 || ob_busy[36]) begin n_fail++; $display("FAIL busy_ignore_extra hwr=%0d idle=%0d busy36=%b exp=1 35 0", n_hwr, idle_c, ob_busy[36]); end
      run_op(3'd3, 32'hFFFF_FFFF, 32'd7, 20, 4);
      n_tests++; if ({ob_busy[21], ob_hwr[21], ob_lwr[21], ob_done[21]} !== 4'b0000 || {ob_hwd[21], ob_lwd[21]} !== 64'h0) begin n_fail++; $display("FAIL rst_mid ctl=%b wd=%h_%h exp=0000 0_0", {ob_busy[21], ob_hwr[21], ob_lwr[21], ob_done[21]}, ob_hwd[21], ob_lwd[21]); end
      n_tests++; if (n_hwr != 0 || n_lwr != 0 || n_done != 0) begin n_fail++; $display("FAIL rst_mid_writes got=%0d/%0d/%0d exp=0/0/0", n_hwr, n_lwr, n_done); end
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         test_op("random", o, a, b);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_move();
      test_flush();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
